// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_t;

endpackage

// File: rtl/lsu_load_extend.sv
// Load lane select and sign/zero extension of a full dmem word.
module lsu_load_extend
    import lsu_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] word,
    input  logic [1:0]       addr,
    input  logic [2:0]       funct3,
    output logic [Width-1:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = addr[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    data = {{(Width-8){byte_lane[7]}}, byte_lane};
            F3_H:    data = {{(Width-16){half_lane[15]}}, half_lane};
            F3_BU:   data = {{(Width-8){1'b0}}, byte_lane};
            F3_HU:   data = {{(Width-16){1'b0}}, half_lane};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: drives a word-addressed dmem, doing read-modify-write for SB/SH.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [Width-1:0] req_addr,
    input  logic [Width-1:0] req_wdata,
    output logic             resp_valid,
    output logic [Width-1:0] resp_rdata,
    output logic             resp_err,
    output logic [Width-1:0] mem_addr,
    output logic             mem_we,
    output logic [Width-1:0] mem_wr_data,
    input  logic [Width-1:0] mem_rd
);

    state_t           state, state_next;
    logic [Width-1:0] hold_addr, hold_data;
    logic [Width-1:0] load_data, merged;
    logic             accept, illegal, misaligned, access_err;
    logic             resp_valid_next, resp_err_next, hold_load;
    logic [Width-1:0] resp_rdata_next;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid & req_ready & ~rst;

    lsu_load_extend #(.Width(Width)) u_load_extend (
        .word   (mem_rd),
        .addr   (req_addr[1:0]),
        .funct3 (req_funct3),
        .data   (load_data)
    );

    always_comb begin
        if (req_we)
            illegal = !(req_funct3 inside {F3_B, F3_H, F3_W});
        else
            illegal = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misaligned = ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) ||
                     ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
        access_err = illegal | misaligned;
    end

    always_comb begin
        merged = mem_rd;
        if (req_funct3 == F3_B) begin
            case (req_addr[1:0])
                2'd0:    merged[7:0]   = req_wdata[7:0];
                2'd1:    merged[15:8]  = req_wdata[7:0];
                2'd2:    merged[23:16] = req_wdata[7:0];
                default: merged[31:24] = req_wdata[7:0];
            endcase
        end else if (req_addr[1]) begin
            merged[31:16] = req_wdata[15:0];
        end else begin
            merged[15:0] = req_wdata[15:0];
        end
    end

    always_comb begin
        state_next      = state;
        resp_valid_next = 1'b0;
        resp_err_next   = 1'b0;
        resp_rdata_next = '0;
        hold_load       = 1'b0;
        mem_addr        = req_addr;
        mem_we          = 1'b0;
        mem_wr_data     = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    resp_valid_next = 1'b1;
                    if (access_err) begin
                        resp_err_next = 1'b1;
                    end else if (!req_we) begin
                        resp_rdata_next = load_data;
                    end else if (req_funct3 == F3_W) begin
                        mem_we      = 1'b1;
                        mem_wr_data = req_wdata;
                    end else begin
                        // sub-word store: read now, write the merged word next cycle
                        resp_valid_next = 1'b0;
                        hold_load       = 1'b1;
                        state_next      = ST_RMW_WR;
                    end
                end
            end
            ST_RMW_WR: begin
                mem_addr        = hold_addr;
                mem_we          = ~rst;
                mem_wr_data     = hold_data;
                resp_valid_next = 1'b1;
                state_next      = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            hold_addr  <= '0;
            hold_data  <= '0;
        end else begin
            state      <= state_next;
            resp_valid <= resp_valid_next;
            resp_err   <= resp_err_next;
            resp_rdata <= resp_rdata_next;
            if (hold_load) begin
                hold_addr <= req_addr;
                hold_data <= merged;
            end
        end
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit in the MEM stage of the pipelined core; it is the initiator side of the data-memory interface.
- The data memory is word-addressed: combinational read, full-word synchronous write only.
- This block converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into that interface: byte-lane extract and sign/zero extension for loads, read-modify-write for sub-word stores.
- It also detects misaligned and illegal accesses.

Parameters:
- Width, 32, datapath/address width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 of the access
- req_addr  in  Width  byte address
- req_wdata  in  Width  store data, low bits significant for SB/SH
- resp_valid  out  1  one-cycle pulse: request complete
- resp_rdata  out  Width  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid: misaligned or illegal funct3
- mem_addr  out  Width  byte address to dmem; dmem uses bits [Width-1:2]
- mem_we  out  1  dmem write enable
- mem_wr_data  out  Width  dmem write data
- mem_rd  in  Width  dmem combinational read data

Behaviour:
- States: IDLE, RMW_WR.
- req_ready = (state==IDLE). Accept = req_valid & req_ready.
- Responses have no backpressure.
- Reset: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, hold registers=0.
- While rst=1, mem_we=0.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- Error access (illegal or misaligned):
  - No write: mem_we=0.
  - Next cycle: resp_valid=1, resp_err=1, resp_rdata=0.
  - State stays IDLE.
- Load, accept cycle:
  - mem_addr=req_addr, mem_we=0.
  - Lane select by addr[1:0] (byte) or addr[1] (half).
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - Result registered. Latency 1: resp_valid and resp_rdata in the next cycle.
- SW, accept cycle:
  - mem_addr=req_addr, mem_we=1, mem_wr_data=req_wdata.
  - resp_valid next cycle; state stays IDLE.
- SB/SH, accept cycle:
  - mem_addr=req_addr, mem_we=0.
  - merged = mem_rd with the addressed lane replaced by req_wdata[7:0] or [15:0].
  - hold_addr <= req_addr; hold_data <= merged; state <= RMW_WR.
- SB/SH, RMW_WR cycle:
  - mem_addr=hold_addr, mem_we=1, mem_wr_data=hold_data, req_ready=0.
  - Next: state <= IDLE, resp_valid=1.
  - Total latency 2; throughput 1 per 2 cycles.
- Idle outputs: mem_we=0, mem_addr=req_addr, mem_wr_data=0.
- A new request is accepted in the cycle that resp_valid of the previous request is high, provided state==IDLE (back-to-back loads/SW run at 1 per cycle).
- rst asserted in RMW_WR: the write is aborted (mem_we forced 0 that cycle), no resp_valid, state → IDLE.
- rst dominates a simultaneous req_valid: nothing is accepted.
- Address range is not checked; the dmem index wraps naturally.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - State encoding ST_IDLE=1'b0, ST_RMW_WR=1'b1.
- Sub-module lsu_load_extend: combinational lane select plus sign/zero extension (inputs word, addr[1:0], funct3; output Width).
- Store merge stays inline.

Test Plan:
- dmem word @0x10 = 0x8899AABB; LB addr 0x11 → next cycle resp_rdata=0xFFFFFFAA, resp_err=0; LBU 0x13 → 0x00000088; LHU 0x12 → 0x00008899; LH 0x10 → 0xFFFFAABB.
- SB 0x12 wdata 0x12345655 on word 0x8899AABB → cycle 0 mem_we=0; cycle 1 mem_we=1, mem_wr_data=0x8855AABB; cycle 2 resp_valid=1; req_ready=0 in cycle 1.
- SH 0x16 wdata 0xCAFE on word @0x14 = 0x00000000 → write 0xCAFE0000. Then SW 0x14 0xDEADBEEF accepted back-to-back in 1 cycle; LW 0x14 → 0xDEADBEEF.
- LW 0x11, SH 0x13, funct3 011 load → each: mem_we never 1; resp_valid next cycle with resp_err=1, resp_rdata=0; memory unchanged.
- Back-to-back LW 0x00, 0x04, 0x08 on consecutive cycles → resp_valid high 3 consecutive cycles with the matching data.
- SB issued, rst=1 during RMW_WR cycle → mem_we=0, no resp_valid; memory word unchanged; after rst low, req_ready=1 and all outputs at reset values.
